// File: rtl/apb_master_arbiter.sv
// Round-robin APB master shared by NREQ requesters; accept -> SETUP -> ACCESS..PREADY -> rsp pulse (min 3 cycles).
// Requesters are held off by req_ready (IDLE only); rsp_valid has no backpressure, a PREADY timeout bounds hung slaves.
module apb_master_arbiter #(
  parameter int NREQ           = 2,
  parameter int PDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IDW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*PDATA_SIZE-1:0]   req_addr,
  input  logic [NREQ*PDATA_SIZE-1:0]   req_wdata,
  input  logic [NREQ*PDATA_SIZE/8-1:0] req_strb,
  input  logic [NREQ*3-1:0]            req_prot,
  output logic                         rsp_valid,
  output logic [IDW-1:0]               rsp_id,
  output logic [PDATA_SIZE-1:0]        rsp_rdata,
  output logic                         rsp_slverr,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [2:0]                   PPROT,
  output logic [PDATA_SIZE-1:0]        PADDR,
  output logic [PDATA_SIZE-1:0]        PWDATA,
  output logic [PDATA_SIZE/8-1:0]      PSTRB,
  input  logic [PDATA_SIZE-1:0]        PRDATA,
  input  logic                         PREADY,
  input  logic                         PSLVERR
);

  localparam int SW = PDATA_SIZE / 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic                  write;
    logic [2:0]            prot;
    logic [PDATA_SIZE-1:0] addr;
    logic [PDATA_SIZE-1:0] wdata;
    logic [SW-1:0]         strb;
  } req_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [TW-1:0]  to_cnt;
  logic           to_hit;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           accept;
  logic           complete;
  logic           timed_out;
  req_t           req_arr [NREQ];
  req_t           req_sel;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_arr[gi] = '{
      write: req_write[gi],
      prot:  req_prot[gi*3 +: 3],
      addr:  req_addr[gi*PDATA_SIZE +: PDATA_SIZE],
      wdata: req_wdata[gi*PDATA_SIZE +: PDATA_SIZE],
      strb:  req_strb[gi*SW +: SW]
    };
  end

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign req_sel = req_arr[grant_id];
  assign to_hit  = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt           = SETUP;
          accept              = 1'b1;
          req_ready[grant_id] = 1'b1;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // PREADY on the timeout edge still wins and completes normally.
        if (PREADY) begin
          state_nxt = IDLE;
          complete  = 1'b1;
        end else if (to_hit) begin
          state_nxt = IDLE;
          complete  = 1'b1;
          timed_out = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr        <= '0;
      owner      <= '0;
      to_cnt     <= '0;
      PWRITE     <= 1'b0;
      PPROT      <= '0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        PWRITE <= req_sel.write;
        PPROT  <= req_sel.prot;
        PADDR  <= req_sel.addr;
        PWDATA <= req_sel.wdata;
        PSTRB  <= req_sel.write ? req_sel.strb : '0;
        owner  <= grant_id;
        ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
      if (state == ACCESS && state_nxt == ACCESS) to_cnt <= to_cnt + 1'b1;
      else                                        to_cnt <= '0;
      if (complete) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= owner;
        rsp_slverr <= timed_out ? 1'b1 : PSLVERR;
        rsp_rdata  <= (timed_out || PWRITE) ? '0 : PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: transaction-level model compared every cycle,
// plus literal expectations for the six scenarios.
module tb_apb_master_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TO   = 16;
  localparam int IDW  = 1;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic [NREQ-1:0]      req_valid, req_ready, req_write;
  logic [NREQ*DW-1:0]   req_addr, req_wdata;
  logic [NREQ*SW-1:0]   req_strb;
  logic [NREQ*3-1:0]    req_prot;
  logic                 rsp_valid, rsp_slverr;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_rdata;
  logic                 PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [2:0]           PPROT;
  logic [DW-1:0]        PADDR, PWDATA, PRDATA;
  logic [SW-1:0]        PSTRB;

  apb_master_arbiter #(.NREQ(NREQ), .PDATA_SIZE(DW), .TIMEOUT_CYCLES(TO), .IDW(IDW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave: PREADY after wait_cycles low ACCESS cycles, never while hang is set.
  logic        hang = 1'b0;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          wait_cycles = 0;
  int          acc_cnt = 0;
  assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_cycles);
  assign PSLVERR = slave_err && PREADY;
  assign PRDATA  = slave_rdata;
  always @(posedge PCLK) acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy/phase flags, ACCESS cycle count, rotating pointer.
  bit          m_busy, m_acc;
  int          m_ncnt, m_ptr, m_owner;
  logic        m_write;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  bit          e_rv;
  int          e_id;
  logic [31:0] e_rdata;
  logic        e_err;

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_busy = 0; m_acc = 0; m_ncnt = 0; m_ptr = 0; e_rv = 0;
    end else begin : mdl
      int g;
      e_rv = 0;
      if (!m_busy) begin
        g = pick();
        if (g >= 0) begin
          m_busy  = 1; m_acc = 0; m_owner = g;
          m_write = req_write[g];
          m_addr  = req_addr[g*DW +: DW];
          m_wdata = req_wdata[g*DW +: DW];
          m_strb  = req_write[g] ? req_strb[g*SW +: SW] : 4'h0;
          m_prot  = req_prot[g*3 +: 3];
          m_ptr   = (g + 1) % NREQ;
        end
      end else if (!m_acc) begin
        m_acc = 1; m_ncnt = 0;
      end else begin
        m_ncnt++;
        if (PREADY) begin
          m_busy = 0; m_acc = 0; e_rv = 1; e_id = m_owner;
          e_err = PSLVERR; e_rdata = m_write ? 32'h0 : PRDATA;
        end else if (TO != 0 && m_ncnt == TO) begin
          m_busy = 0; m_acc = 0; e_rv = 1; e_id = m_owner;
          e_err = 1'b1; e_rdata = 32'h0;
        end
      end
    end
  end

  typedef struct {int id; logic [31:0] rdata; logic err;} rsp_rec_t;
  rsp_rec_t    rsp_q[$];
  int          grant_q[$];
  int          psel_cnt = 0, pen_cnt = 0;
  logic [3:0]  pstrb_or = '0;

  always @(negedge PCLK) begin : cmp
    logic [NREQ-1:0] e_ready;
    int g;
    e_ready = '0;
    if (!m_busy) begin
      g = pick();
      if (g >= 0) e_ready[g] = 1'b1;
    end
    chk("req_ready", req_ready, e_ready);
    chk("psel", PSEL, m_busy);
    chk("penable", PENABLE, m_busy && m_acc);
    chk("rsp_valid", rsp_valid, e_rv);
    if (m_busy) begin
      chk("paddr", PADDR, m_addr);
      chk("pwrite", PWRITE, m_write);
      chk("pwdata", PWDATA, m_wdata);
      chk("pstrb", PSTRB, m_strb);
      chk("pprot", PPROT, m_prot);
    end
    if (e_rv && rsp_valid) begin
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_slverr", rsp_slverr, e_err);
    end
    if (PSEL) begin psel_cnt++; pstrb_or |= PSTRB; end
    if (PENABLE) pen_cnt++;
    for (int k = 0; k < NREQ; k++) if (req_ready[k] && req_valid[k]) grant_q.push_back(k);
    if (rsp_valid) rsp_q.push_back('{int'(rsp_id), rsp_rdata, rsp_slverr});
  end

  task automatic set_req(input int id, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_write[id] = w;
    req_addr[id*DW +: DW] = a;
    req_wdata[id*DW +: DW] = d;
    req_strb[id*SW +: SW] = s;
    req_prot[id*3 +: 3] = p;
  endtask

  task automatic issue(input int id, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    bit done;
    done = 0;
    @(posedge PCLK); #1;
    set_req(id, w, a, d, s, p);
    req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge PCLK);
      if (req_ready[id]) begin
        @(posedge PCLK); #1;
        req_valid[id] = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      req_valid[id] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge PCLK); #1;
      if (rsp_q.size() >= target) ok = 1;
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #10;
    PRESETn = 1'b1;
  endtask

  int rb, gb, rq;
  int exp_order [4] = '{0, 1, 0, 1};

  initial begin
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    #3;
    chk("rst_psel", PSEL, 0);      chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);  chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);  chk("rst_pstrb", PSTRB, 0);
    chk("rst_pprot", PPROT, 0);    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);  chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_slverr", rsp_slverr, 0);
    #9 PRESETn = 1'b1;

    // 1: write, PREADY immediately
    psel_cnt = 0; pen_cnt = 0; rb = rsp_q.size();
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3'h0);
    wait_rsp(rb + 1);
    chk("s1_psel_cycles", psel_cnt, 2);
    chk("s1_penable_cycles", pen_cnt, 1);
    if (rsp_q.size() > rb) begin
      chk("s1_id", rsp_q[rb].id, 0);
      chk("s1_err", rsp_q[rb].err, 0);
      chk("s1_rdata", rsp_q[rb].rdata, 32'h0);
    end

    // 2: read with 3 wait states, strobes forced to zero
    wait_cycles = 3; slave_rdata = 32'h12345678;
    psel_cnt = 0; pen_cnt = 0; pstrb_or = '0; rb = rsp_q.size();
    issue(1, 1'b0, 32'h20, 32'hAAAA5555, 4'hF, 3'h2);
    wait_rsp(rb + 1);
    chk("s2_access_cycles", pen_cnt, 4);
    chk("s2_psel_cycles", psel_cnt, 5);
    chk("s2_pstrb_zero", pstrb_or, 0);
    if (rsp_q.size() > rb) begin
      chk("s2_id", rsp_q[rb].id, 1);
      chk("s2_rdata", rsp_q[rb].rdata, 32'h12345678);
      chk("s2_err", rsp_q[rb].err, 0);
    end

    // 3: both valid from reset, round-robin
    do_reset();
    wait_cycles = 0; slave_rdata = 32'h55AA00FF;
    gb = grant_q.size(); rb = rsp_q.size();
    @(posedge PCLK); #1;
    set_req(0, 1'b1, 32'h300, 32'h11112222, 4'h3, 3'h1);
    set_req(1, 1'b0, 32'h304, 32'h0, 4'hC, 3'h4);
    req_valid = 2'b11;
    for (int c = 0; c < 100 && grant_q.size() < gb + 4; c++) @(negedge PCLK);
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    wait_rsp(rb + 4);
    if (grant_q.size() >= gb + 4 && rsp_q.size() >= rb + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("s3_grant_order", grant_q[gb + k], exp_order[k]);
        chk("s3_rsp_id", rsp_q[rb + k].id, exp_order[k]);
      end
    end else chk("s3_count", grant_q.size() - gb, 4);

    // 4: hung slave times out, then a normal read
    hang = 1'b1; slave_rdata = 32'hCAFEF00D;
    pen_cnt = 0; rb = rsp_q.size();
    issue(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'h0);
    wait_rsp(rb + 1);
    chk("s4_access_cycles", pen_cnt, 16);
    if (rsp_q.size() > rb) begin
      chk("s4_err", rsp_q[rb].err, 1);
      chk("s4_rdata", rsp_q[rb].rdata, 32'h0);
    end
    hang = 1'b0; wait_cycles = 1; rb = rsp_q.size();
    issue(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'h0);
    wait_rsp(rb + 1);
    if (rsp_q.size() > rb) begin
      chk("s4b_err", rsp_q[rb].err, 0);
      chk("s4b_rdata", rsp_q[rb].rdata, 32'hCAFEF00D);
      chk("s4b_id", rsp_q[rb].id, 1);
    end

    // 5: reset during ACCESS
    hang = 1'b1; wait_cycles = 0;
    issue(0, 1'b1, 32'h80, 32'h87654321, 4'h5, 3'h0);
    @(negedge PCLK);
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    chk("s5_psel_async", PSEL, 0);
    chk("s5_penable_async", PENABLE, 0);
    rq = rsp_q.size();
    #9 PRESETn = 1'b1;
    repeat (5) @(negedge PCLK);
    chk("s5_no_rsp", rsp_q.size(), rq);
    hang = 1'b0;
    @(posedge PCLK); #1;
    set_req(0, 1'b1, 32'h88, 32'h01020304, 4'hF, 3'h0);
    set_req(1, 1'b1, 32'h8C, 32'h05060708, 4'hF, 3'h0);
    req_valid = 2'b11;
    @(negedge PCLK);
    chk("s5_ptr_after_reset", req_ready, 2'b01);
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    wait_rsp(rq + 1);
    if (rsp_q.size() > rq) begin
      chk("s5_id", rsp_q[rq].id, 0);
      chk("s5_err", rsp_q[rq].err, 0);
    end

    // 6: slave error on a write, clean read after
    slave_err = 1'b1; rb = rsp_q.size();
    issue(1, 1'b1, 32'h90, 32'h0F0F0F0F, 4'hA, 3'h3);
    wait_rsp(rb + 1);
    slave_err = 1'b0; slave_rdata = 32'h0BADF00D;
    issue(0, 1'b0, 32'h94, 32'h0, 4'hF, 3'h0);
    wait_rsp(rb + 2);
    if (rsp_q.size() > rb + 1) begin
      chk("s6_err_write", rsp_q[rb].err, 1);
      chk("s6_rdata_write", rsp_q[rb].rdata, 32'h0);
      chk("s6_err_read", rsp_q[rb + 1].err, 0);
      chk("s6_rdata_read", rsp_q[rb + 1].rdata, 32'h0BADF00D);
    end

    repeat (3) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end

endmodule
